pc_pipe_shift: RTL and testbench

- Parametrised PC/branch-target delay pipeline that carries the fetch-stage PC, branch target and compressed flag down to execute.
- Configurable width and stage count.
- Per-stage valid bits.
- Global stall with a programmable post-stall hold extension.
- Pipeline flush.
- Computed fall-through PC (+2 or +4) and a random-access stage tap for debug/forwarding.

---
 rtl/pc_pipe_shift_if.sv | 36 +++
 rtl/pc_pipe_shift.sv | 88 ++++++++
 tb/tb_pc_pipe_shift.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_pipe_shift_if.sv
// Bundle of the PC delay pipeline's data, control and observation signals.
// The slave modport is the pipeline side; the master modport is the fetch/debug side.
interface pc_pipe_shift_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNTW  = $clog2(DEPTH + 1)
);
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] target_in;
    logic            compressed_in;
    logic            valid_in;
    logic            stall;
    logic            flush;
    logic [TAPW-1:0] tap_sel;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] target_out;
    logic [XLEN-1:0] pc_next_out;
    logic            valid_out;
    logic [XLEN-1:0] tap_pc;
    logic            tap_valid;
    logic [CNTW-1:0] occupancy;
    logic            frozen;

    modport master (
        output pc_in, target_in, compressed_in, valid_in, stall, flush, tap_sel,
        input  pc_out, target_out, pc_next_out, valid_out, tap_pc, tap_valid,
               occupancy, frozen
    );

    modport slave (
        input  pc_in, target_in, compressed_in, valid_in, stall, flush, tap_sel,
        output pc_out, target_out, pc_next_out, valid_out, tap_pc, tap_valid,
               occupancy, frozen
    );
endinterface

// File: rtl/pc_pipe_shift.sv
// PC / branch-target delay line from fetch to execute with stall, post-stall
// hold extension, flush, fall-through PC and a random-access debug tap.
module pc_pipe_shift #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int STALL_EXT = 1,
    parameter int TAPW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    pc_pipe_shift_if.slave bus
);
    logic [XLEN-1:0]  r_pc  [DEPTH];
    logic [XLEN-1:0]  r_tar [DEPTH];
    logic [DEPTH-1:0] r_c;
    logic [DEPTH-1:0] r_v;
    logic [3:0]       r_ext_cnt;

    logic             w_freeze;
    logic [CNTW-1:0]  w_occ;
    logic [XLEN-1:0]  w_tap_pc;
    logic             w_tap_v;

    assign w_freeze = bus.stall | (r_ext_cnt != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]  <= '0;
                r_tar[i] <= '0;
            end
            r_c       <= '0;
            r_v       <= '0;
            r_ext_cnt <= '0;
        end else begin
            // Flush only kills valids; stale data stays put until the next advance.
            if (bus.flush) begin
                r_v <= '0;
            end else if (!w_freeze) begin
                r_pc[0]  <= bus.pc_in;
                r_tar[0] <= bus.target_in;
                r_c[0]   <= bus.compressed_in;
                r_v[0]   <= bus.valid_in;
                for (int i = 1; i < DEPTH; i++) begin
                    r_pc[i]  <= r_pc[i-1];
                    r_tar[i] <= r_tar[i-1];
                    r_c[i]   <= r_c[i-1];
                    r_v[i]   <= r_v[i-1];
                end
            end

            // Stall reloads the extension even when it coincides with a flush.
            if (bus.stall) begin
                r_ext_cnt <= 4'(STALL_EXT);
            end else if (bus.flush) begin
                r_ext_cnt <= 4'd0;
            end else if (r_ext_cnt != 4'd0) begin
                r_ext_cnt <= r_ext_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + CNTW'(r_v[i]);
        end
    end

    always_comb begin
        w_tap_pc = '0;
        w_tap_v  = 1'b0;
        if (int'(bus.tap_sel) < DEPTH) begin
            w_tap_pc = r_pc[bus.tap_sel];
            w_tap_v  = r_v[bus.tap_sel];
        end
    end

    assign bus.pc_out      = r_pc[DEPTH-1];
    assign bus.target_out  = r_tar[DEPTH-1];
    assign bus.pc_next_out = r_pc[DEPTH-1] + (r_c[DEPTH-1] ? XLEN'(2) : XLEN'(4));
    assign bus.valid_out   = r_v[DEPTH-1];
    assign bus.tap_pc      = w_tap_pc;
    assign bus.tap_valid   = w_tap_v;
    assign bus.occupancy   = w_occ;
    assign bus.frozen      = w_freeze;
endmodule

// File: tb/tb_pc_pipe_shift.sv
// Scenario bench for pc_pipe_shift: a DEPTH=4 instance for the main checks and a
// DEPTH=3 instance to exercise the out-of-range tap select.
module tb_pc_pipe_shift;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tar;
        logic [31:0] nxt;
        logic        v;
    } exp_t;

    exp_t q[$];
    exp_t e;

    pc_pipe_shift_if #(.XLEN(32), .DEPTH(4)) bus ();
    pc_pipe_shift_if #(.XLEN(32), .DEPTH(3)) bus3 ();

    pc_pipe_shift #(.XLEN(32), .DEPTH(4), .STALL_EXT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_pipe_shift #(.XLEN(32), .DEPTH(3), .STALL_EXT(1)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    assign bus3.pc_in         = bus.pc_in;
    assign bus3.target_in     = bus.target_in;
    assign bus3.compressed_in = bus.compressed_in;
    assign bus3.valid_in      = bus.valid_in;
    assign bus3.stall         = bus.stall;
    assign bus3.flush         = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        bus.pc_in         = '0;
        bus.target_in     = '0;
        bus.compressed_in = 1'b0;
        bus.valid_in      = 1'b0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.tap_sel       = '0;
        bus3.tap_sel      = '0;
        tick();
        tick();
        total++; if (bus.pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out got=%h exp=%h", bus.pc_out, 32'h0); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.pc_next_out !== 32'h4) begin bad++; $display("FAIL rst_pc_next got=%h exp=%h", bus.pc_next_out, 32'h4); end
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL rst_frozen got=%b exp=0", bus.frozen); end
        total++; if (bus.target_out !== 32'h0) begin bad++; $display("FAIL rst_target got=%h exp=0", bus.target_out); end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        logic [2:0] occ_exp;
        for (int k = 0; k < 5; k++) begin
            bus.pc_in     = 32'h100 + 32'(4 * k);
            bus.target_in = 32'h1000 + 32'(k);
            bus.valid_in  = 1'b1;
            e.pc = bus.pc_in; e.tar = bus.target_in; e.nxt = 32'h0; e.v = 1'b1;
            q.push_back(e);
            tick();
            occ_exp = (k < 3) ? 3'(k + 1) : 3'd4;
            total++; if (bus.occupancy !== occ_exp) begin bad++; $display("FAIL fill_occ k=%0d got=%0d exp=%0d", k, bus.occupancy, occ_exp); end
            if (k >= 3) begin
                e = q.pop_front();
                total++; if (bus.pc_out !== e.pc) begin bad++; $display("FAIL fill_pc k=%0d got=%h exp=%h", k, bus.pc_out, e.pc); end
                total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL fill_valid k=%0d got=%b exp=1", k, bus.valid_out); end
            end
        end
    endtask

    task automatic test_stall_ext();
        bus.stall    = 1'b1;
        bus.valid_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.stall = 1'b0;
            bus.pc_in = 32'hBAD0 + 32'(c);
            #1;
            total++; if (bus.frozen !== 1'b1) begin bad++; $display("FAIL stall_frozen c=%0d got=%b exp=1", c, bus.frozen); end
            tick();
            total++; if (bus.pc_out !== 32'h104) begin bad++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, bus.pc_out, 32'h104); end
        end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", bus.frozen); end
        for (int k = 0; k < 4; k++) begin
            bus.pc_in     = 32'h114 + 32'(4 * k);
            bus.target_in = 32'h2000 + 32'(k);
            e.pc = bus.pc_in; e.tar = bus.target_in; e.nxt = 32'h0; e.v = 1'b1;
            q.push_back(e);
            tick();
            if (q.size() == 0) begin
                total++; bad++; $display("FAIL stall_queue_empty k=%0d", k);
            end else begin
                e = q.pop_front();
                total++; if (bus.pc_out !== e.pc) begin bad++; $display("FAIL stall_resume k=%0d got=%h exp=%h", k, bus.pc_out, e.pc); end
            end
        end
    endtask

    task automatic test_flush();
        bus.flush    = 1'b1;
        bus.valid_in = 1'b1;
        bus.pc_in    = 32'hBAD9;
        tick();
        bus.flush    = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.pc_out !== 32'h114) begin bad++; $display("FAIL flush_pc_hold got=%h exp=%h", bus.pc_out, 32'h114); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL flush_frozen got=%b exp=0", bus.frozen); end
        q.delete();

        bus.pc_in    = 32'h300;
        bus.valid_in = 1'b1;
        tick();
        total++; if (bus.occupancy !== 3'd1) begin bad++; $display("FAIL post_flush_occ got=%0d exp=1", bus.occupancy); end
        total++; if (bus.pc_out !== 32'h118) begin bad++; $display("FAIL post_flush_pc got=%h exp=%h", bus.pc_out, 32'h118); end

        bus.stall = 1'b1;
        bus.flush = 1'b1;
        bus.pc_in = 32'hBADA;
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        #1;
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL sf_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.frozen !== 1'b1) begin bad++; $display("FAIL sf_ext_frozen got=%b exp=1", bus.frozen); end
        tick();
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL sf_drop occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL sf_ext_end got=%b exp=0", bus.frozen); end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_compressed_wrap();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin
                    bus.pc_in = 32'h200; bus.target_in = 32'hDEAD0000;
                    bus.compressed_in = 1'b1; bus.valid_in = 1'b1;
                    e.pc = 32'h200; e.tar = 32'hDEAD0000; e.nxt = 32'h202; e.v = 1'b1;
                end
                1: begin
                    bus.pc_in = 32'hFFFFFFFE; bus.target_in = 32'h12345678;
                    bus.compressed_in = 1'b0; bus.valid_in = 1'b1;
                    e.pc = 32'hFFFFFFFE; e.tar = 32'h12345678; e.nxt = 32'h2; e.v = 1'b1;
                end
                default: begin
                    bus.pc_in = 32'h0; bus.target_in = 32'h0;
                    bus.compressed_in = 1'b0; bus.valid_in = 1'b0;
                    e.pc = 32'h0; e.tar = 32'h0; e.nxt = 32'h4; e.v = 1'b0;
                end
            endcase
            q.push_back(e);
            tick();
            if (k >= 3) begin
                e = q.pop_front();
                total++; if (bus.valid_out !== e.v) begin bad++; $display("FAIL cw_valid k=%0d got=%b exp=%b", k, bus.valid_out, e.v); end
                if (e.v) begin
                    total++; if (bus.pc_out !== e.pc) begin bad++; $display("FAIL cw_pc k=%0d got=%h exp=%h", k, bus.pc_out, e.pc); end
                    total++; if (bus.target_out !== e.tar) begin bad++; $display("FAIL cw_target k=%0d got=%h exp=%h", k, bus.target_out, e.tar); end
                    total++; if (bus.pc_next_out !== e.nxt) begin bad++; $display("FAIL cw_next k=%0d got=%h exp=%h", k, bus.pc_next_out, e.nxt); end
                end
            end
        end
        q.delete();
    endtask

    task automatic test_taps();
        logic [31:0] tap_exp [4];
        tap_exp[0] = 32'h1C; tap_exp[1] = 32'h18; tap_exp[2] = 32'h14; tap_exp[3] = 32'h10;
        for (int k = 0; k < 4; k++) begin
            bus.pc_in     = 32'h10 + 32'(4 * k);
            bus.target_in = 32'h0;
            bus.valid_in  = 1'b1;
            tick();
        end
        bus.valid_in = 1'b0;
        total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL tap_occ got=%0d exp=4", bus.occupancy); end
        for (int i = 0; i < 4; i++) begin
            bus.tap_sel = 2'(i);
            #1;
            total++; if (bus.tap_pc !== tap_exp[i]) begin bad++; $display("FAIL tap_pc sel=%0d got=%h exp=%h", i, bus.tap_pc, tap_exp[i]); end
            total++; if (bus.tap_valid !== 1'b1) begin bad++; $display("FAIL tap_valid sel=%0d got=%b exp=1", i, bus.tap_valid); end
        end
        bus3.tap_sel = 2'd1;
        #1;
        total++; if (bus3.tap_pc !== 32'h18) begin bad++; $display("FAIL tap3_in_range got=%h exp=%h", bus3.tap_pc, 32'h18); end
        bus3.tap_sel = 2'd3;
        #1;
        total++; if (bus3.tap_pc !== 32'h0) begin bad++; $display("FAIL tap3_oor_pc got=%h exp=0", bus3.tap_pc); end
        total++; if (bus3.tap_valid !== 1'b0) begin bad++; $display("FAIL tap3_oor_valid got=%b exp=0", bus3.tap_valid); end
        bus.tap_sel = 2'd0;
    endtask

    task automatic test_async_reset();
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        #1;
        total++; if (bus.frozen !== 1'b1) begin bad++; $display("FAIL ar_pre_frozen got=%b exp=1", bus.frozen); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.pc_out !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h exp=0", bus.pc_out); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL ar_occ got=%0d exp=0", bus.occupancy); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL ar_frozen got=%b exp=0", bus.frozen); end
        total++; if (bus.pc_next_out !== 32'h4) begin bad++; $display("FAIL ar_next got=%h exp=%h", bus.pc_next_out, 32'h4); end
        #1 reset = 1'b1;
        bus.pc_in    = 32'h400;
        bus.valid_in = 1'b1;
        bus.tap_sel  = 2'd0;
        tick();
        bus.valid_in = 1'b0;
        total++; if (bus.tap_pc !== 32'h400) begin bad++; $display("FAIL ar_first_pc got=%h exp=%h", bus.tap_pc, 32'h400); end
        total++; if (bus.tap_valid !== 1'b1) begin bad++; $display("FAIL ar_first_valid got=%b exp=1", bus.tap_valid); end
        total++; if (bus.occupancy !== 3'd1) begin bad++; $display("FAIL ar_first_occ got=%0d exp=1", bus.occupancy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_stall_ext();
        test_flush();
        test_compressed_wrap();
        test_taps();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
